// File: rtl/csr_fifo_pkg.sv
// Shared definitions for the CSR show-ahead FIFO controller: depth/pointer helpers,
// default watermark thresholds and the output-stage state encoding.
package csr_fifo_pkg;

  localparam int DEFAULT_PTR_WIDTH = 3;
  localparam int DEFAULT_PTR_BITS  = DEFAULT_PTR_WIDTH + 1;
  localparam int DEFAULT_AF_THRESH = 6;
  localparam int DEFAULT_AE_THRESH = 1;

  // rd_vld is the output-stage state: EMPTY holds nothing, VALID presents the head entry.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  function automatic int fifo_depth(input int ptr_width);
    return 1 << ptr_width;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_bits(input int ptr_width);
    return ptr_width + 1;
  endfunction

endpackage

// File: rtl/csr_fifo_ctrl_mem.sv
// Simple dual-port storage for the CSR FIFO: one write port, one registered read port.
// DEPTH is the highest address index, so the array holds DEPTH+1 entries.
module mem_1w1r_fpga_or_sim #(
  parameter int DEPTH      = 7,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 39
) (
  input  logic                  wclk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rclk,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH];

  always_ff @(posedge wclk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register is the FIFO head; it only changes when a new entry is fetched.
  always_ff @(posedge rclk) begin
    if (ren) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/csr_fifo_ctrl.sv
// Show-ahead FIFO controller turning a registered-read 1W1R memory into a valid/ready stream.
// Optional registered almost_full/almost_empty flags are enabled by CSR_FIFO_WATERMARK_EN.
module csr_fifo_ctrl
  import csr_fifo_pkg::*;
#(
  parameter int PTR_WIDTH  = DEFAULT_PTR_WIDTH,
  parameter int DATA_WIDTH = 39,
  parameter int AF_THRESH  = DEFAULT_AF_THRESH,
  parameter int AE_THRESH  = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PTR_WIDTH:0]    level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int DEPTH = fifo_depth(PTR_WIDTH);
  localparam int PB    = ptr_bits(PTR_WIDTH);
  localparam logic [PB-1:0] FULL_LEVEL = PB'(DEPTH);

  if (AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_bad_thresh
    $error("csr_fifo_ctrl: watermark thresholds must not exceed the FIFO depth");
  end

  logic [PB-1:0] wptr;
  logic [PB-1:0] rptr;
  logic [PB-1:0] ram_cnt;
  logic [PB-1:0] level_next;
  out_state_t    state;
  logic          push;
  logic          pop;
  logic          fetch;
  logic          wen;
  logic          ren;

  assign rd_vld  = (state == OUT_VALID);
  assign wr_rdy  = (level < FULL_LEVEL);
  assign push    = wr_vld & wr_rdy;
  assign pop     = rd_vld & rd_rdy;
  // Registered pointers only: an entry becomes fetchable the cycle after its write.
  assign ram_cnt = wptr - rptr;
  assign fetch   = (ram_cnt != '0) & (~rd_vld | pop);
  assign wen     = push & ~flush;
  assign ren     = fetch & ~flush;

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (!push && pop) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      state <= OUT_EMPTY;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      state <= OUT_EMPTY;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (fetch) begin
        rptr <= rptr + 1'b1;
      end
      case (state)
        OUT_EMPTY: if (fetch) state <= OUT_VALID;
        OUT_VALID: if (pop && !fetch) state <= OUT_EMPTY;
        default:   state <= OUT_EMPTY;
      endcase
      level <= level_next;
    end
  end

`ifdef CSR_FIFO_WATERMARK_EN
  localparam logic [PB-1:0] AF_LEVEL = PB'(AF_THRESH);
  localparam logic [PB-1:0] AE_LEVEL = PB'(AE_THRESH);

  // Flags follow the next level so they line up with the level register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_next >= AF_LEVEL);
      almost_empty <= (level_next <= AE_LEVEL);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  mem_1w1r_fpga_or_sim #(
    .DEPTH      (DEPTH - 1),
    .ADDR_WIDTH (PTR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .wclk  (clk),
    .wen   (wen),
    .waddr (wptr[PTR_WIDTH-1:0]),
    .wdata (wr_data),
    .rclk  (clk),
    .ren   (ren),
    .raddr (rptr[PTR_WIDTH-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_csr_fifo_ctrl.sv
// Directed bench for csr_fifo_ctrl with a behavioural level/valid model and a data scoreboard.
// Build with CSR_FIFO_WATERMARK_EN to also check the watermark flags.
module tb_csr_fifo_ctrl;

  localparam int PTR_WIDTH  = 3;
  localparam int DATA_WIDTH = 39;
  localparam int DEPTH      = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  wr_vld;
  logic                  wr_rdy;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_vld;
  logic                  rd_rdy;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [PTR_WIDTH:0]    level;
  logic                  almost_full;
  logic                  almost_empty;

  csr_fifo_ctrl #(
    .PTR_WIDTH  (PTR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AF_THRESH  (6),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_vld       (wr_vld),
    .wr_rdy       (wr_rdy),
    .wr_data      (wr_data),
    .rd_vld       (rd_vld),
    .rd_rdy       (rd_rdy),
    .rd_data      (rd_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  logic [DATA_WIDTH-1:0] sb[$];
  int   m_level;
  logic m_vld;
  logic m_af;
  logic m_ae;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_vld   = 1'b0;
    m_af    = 1'b0;
    m_ae    = 1'b1;
    sb.delete();
  endtask

  // Checks the current cycle against the model, then advances model and DUT by one edge.
  task automatic step();
    logic m_push;
    logic m_pop;
    logic m_fetch;
    int   m_ram;
    @(negedge clk);
    check("wr_rdy", 64'(wr_rdy), 64'(m_level < DEPTH));
    check("level", 64'(level), 64'(m_level));
    check("rd_vld", 64'(rd_vld), 64'(m_vld));
`ifdef CSR_FIFO_WATERMARK_EN
    check("almost_full", 64'(almost_full), 64'(m_af));
    check("almost_empty", 64'(almost_empty), 64'(m_ae));
`else
    check("almost_full", 64'(almost_full), 64'(0));
    check("almost_empty", 64'(almost_empty), 64'(0));
`endif
    if (m_vld && sb.size() > 0) begin
      check("rd_data", 64'(rd_data), 64'(sb[0]));
    end
    m_push  = wr_vld && (m_level < DEPTH) && !flush;
    m_pop   = rd_rdy && m_vld && !flush;
    m_ram   = m_level - int'(m_vld);
    m_fetch = (m_ram != 0) && (!m_vld || m_pop) && !flush;
    if (flush) begin
      m_level = 0;
      m_vld   = 1'b0;
      sb.delete();
    end else begin
      if (m_push) sb.push_back(wr_data);
      if (m_pop) begin
        void'(sb.pop_front());
        pops++;
      end
      m_level = m_level + int'(m_push) - int'(m_pop);
      m_vld   = m_fetch || (m_vld && !m_pop);
    end
    m_af = (m_level >= 6);
    m_ae = (m_level <= 1);
    $display("t=%0t wr_vld=%0b wr_data=%0h rd_rdy=%0b flush=%0b rd_vld=%0b rd_data=%0h level=%0d",
             $time, wr_vld, wr_data, rd_rdy, flush, rd_vld, rd_data, level);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    wr_vld  = 1'b0;
    wr_data = '0;
    rd_rdy  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset takes effect mid-cycle.
    wr_vld = 1'b1; wr_data = 39'h55;
    step();
    wr_vld = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_rd_vld", 64'(rd_vld), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_wr_rdy", 64'(wr_rdy), 64'(1));
    model_reset();
    #2 rst = 1'b0;
    step();

    // Single push: level after one cycle, head valid after two.
    wr_vld = 1'b1; wr_data = 39'h01;
    step();
    wr_vld = 1'b0;
    step();
    step();
    rd_rdy = 1'b1;
    step();
    rd_rdy = 1'b0;
    step();

    // Fill to full, an ignored push, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      wr_vld = 1'b1; wr_data = 39'(32'h10 + i);
      step();
    end
    wr_data = 39'h18;
    step();
    step();
    wr_vld = 1'b0; rd_rdy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("drain_empty", 64'(sb.size()), 64'(0));
    rd_rdy = 1'b0;

    // Streaming push+pop through several pointer wraps.
    pops = 0;
    rd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_vld = 1'b1; wr_data = 39'(32'h100 + i);
      step();
    end
    wr_vld = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("stream_pops", 64'(pops), 64'(20));
    rd_rdy = 1'b0;

    // Flush with a concurrent offered word discards everything.
    for (int i = 0; i < 5; i++) begin
      wr_vld = 1'b1; wr_data = 39'(32'h200 + i);
      step();
    end
    wr_vld = 1'b1; wr_data = 39'hAA; flush = 1'b1;
    step();
    wr_vld = 1'b0; flush = 1'b0;
    pops = 0;
    rd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("flush_no_data", 64'(pops), 64'(0));

    // Watermarks ramp: levels 0..7 then back down.
    rd_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_vld = 1'b1; wr_data = 39'(32'h300 + i);
      step();
    end
    wr_vld = 1'b0; rd_rdy = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("final_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
